// File: rtl/gascon_pkg.sv
// Shared GASCON definitions: round limit, FSM state type, rotation tables,
// round-constant helper, byte-swap and interleaved rotation helpers.
package gascon_pkg;

    localparam int unsigned GASCON_MAX_ROUNDS = 12;

    typedef enum logic [1:0] {StIdle, StRun, StDone} gascon_st_e;

    // First rotation amount of the linear layer, per state word.
    function automatic int unsigned rot0(input int unsigned word);
        int unsigned r;
        case (word)
            0: r = 19;
            1: r = 61;
            2: r = 1;
            3: r = 10;
            4: r = 7;
            5: r = 31;
            6: r = 53;
            7: r = 9;
            8: r = 43;
            default: r = 0;
        endcase
        return r;
    endfunction

    // Second rotation amount of the linear layer, per state word.
    function automatic int unsigned rot1(input int unsigned word);
        int unsigned r;
        case (word)
            0: r = 28;
            1: r = 38;
            2: r = 6;
            3: r = 17;
            4: r = 40;
            5: r = 26;
            6: r = 58;
            7: r = 46;
            8: r = 50;
            default: r = 0;
        endcase
        return r;
    endfunction

    // Round constant {0xF - idx, idx} in the low byte of a word.
    function automatic logic [63:0] round_cst(input logic [3:0] idx);
        return {56'd0, 4'hF - idx, idx};
    endfunction

    function automatic logic [63:0] swap_endian64(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            y[8*i +: 8] = x[8*(7-i) +: 8];
        end
        return y;
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned s);
        return (x >> s) | (x << (32 - s));
    endfunction

    // Words are bit-interleaved: even bits in [31:0], odd bits in [63:32].
    // An odd rotation swaps the halves; the half that came from the even
    // bits picks up one extra position.
    function automatic logic [63:0] rotr64_interleaved(input logic [63:0] x,
                                                       input int unsigned shift);
        int unsigned half;
        logic [31:0] lo;
        logic [31:0] hi;
        half = shift / 2;
        if ((shift % 2) != 0) begin
            lo = rotr32(x[63:32], half);
            hi = rotr32(x[31:0], (half + 1) % 32);
        end else begin
            lo = rotr32(x[31:0], half);
            hi = rotr32(x[63:32], half);
        end
        return {hi, lo};
    endfunction

endpackage

// File: rtl/gascon_round.sv
// One combinational GASCON round.
// Ports:
//   in_state  [64*NW]  state in, word 0 in MSBs, each word little-endian bytes
//   round     [4]      round index (constant selector)
//   out_state [64*NW]  state after constant add, S-box layer and linear layer
module gascon_round
    import gascon_pkg::*;
#(
    parameter int unsigned NW = 5
) (
    input  logic [64*NW-1:0] in_state,
    input  logic [3:0]       round,
    output logic [64*NW-1:0] out_state
);

    localparam int unsigned MID = NW / 2;

    function automatic logic [64*NW-1:0] do_round(input logic [64*NW-1:0] s,
                                                  input logic [3:0] idx);
        logic [63:0] x [NW];
        logic [63:0] t [NW];
        logic [63:0] w;
        logic [64*NW-1:0] r;
        r = '0;
        for (int i = 0; i < NW; i++) begin
            x[i] = swap_endian64(s[64*(NW-i)-1 -: 64]);
        end
        x[MID] = x[MID] ^ round_cst(idx);
        // S-box entry mix; order matters (x0 must see the old x[NW-1]).
        for (int i = 0; i <= MID; i++) begin
            x[2*i] = x[2*i] ^ x[(NW + 2*i - 1) % NW];
        end
        for (int i = 0; i < NW; i++) begin
            t[i] = ~x[i] & x[(i + 1) % NW];
        end
        for (int i = 0; i < NW; i++) begin
            x[i] = x[i] ^ t[(i + 1) % NW];
        end
        // S-box exit mix; last step wraps onto x0 using the updated x[NW-1].
        for (int i = 0; i <= MID; i++) begin
            x[(2*i + 1) % NW] = x[(2*i + 1) % NW] ^ x[2*i];
        end
        x[MID] = ~x[MID];
        for (int i = 0; i < NW; i++) begin
            w = x[i];
            x[i] = w ^ rotr64_interleaved(w, rot0(i)) ^ rotr64_interleaved(w, rot1(i));
        end
        for (int i = 0; i < NW; i++) begin
            r[64*(NW-i)-1 -: 64] = swap_endian64(x[i]);
        end
        return r;
    endfunction

    always_comb begin
        out_state = do_round(in_state, round);
    end

endmodule

// File: rtl/gascon_perm_iter.sv
// Multi-cycle GASCON permutation engine: applies 0..12 rounds to a 64*NW-bit
// state, UNROLL rounds per clock, with a valid/ready handshake on both sides.
// Optional macro GASCON_PERM_ZEROIZE_EN: clear the state register when the
// result is taken, so out_state reads zero while idle.
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid/in_ready    request handshake (ready only while idle)
//   in_state, in_rounds  state to permute; round count (>12 treated as 12)
//   out_valid/out_ready  result handshake, result held until taken
//   out_state            permuted state
//   busy                 engine running or holding a result
module gascon_perm_iter
    import gascon_pkg::*;
#(
    parameter int unsigned NW     = 5,
    parameter int unsigned UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [64*NW-1:0] in_state,
    input  logic [3:0]       in_rounds,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [64*NW-1:0] out_state,
    output logic             busy
);

    localparam int unsigned SW = 64 * NW;

    gascon_st_e  st_q, st_d;
    logic [SW-1:0] state_q, state_d;
    logic [3:0]  rnd_q, rnd_d;
    logic [3:0]  rem_q, rem_d;
    logic [3:0]  rounds_sat;
    logic [3:0]  step;
    logic [SW-1:0] perm_out;

    // Stage k applies round rnd_q+k only while k is below the remaining count.
    for (genvar k = 0; k < UNROLL; k++) begin : g_stage
        logic [SW-1:0] s_in;
        logic [SW-1:0] s_rnd;
        logic [SW-1:0] s_out;
        logic [3:0]    idx;

        if (k == 0) begin : g_first
            assign s_in = state_q;
        end else begin : g_next
            assign s_in = g_stage[k-1].s_out;
        end

        assign idx = rnd_q + 4'(k);

        gascon_round #(
            .NW (NW)
        ) u_round (
            .in_state  (s_in),
            .round     (idx),
            .out_state (s_rnd)
        );

        assign s_out = (4'(k) < rem_q) ? s_rnd : s_in;
    end

    assign perm_out   = g_stage[UNROLL-1].s_out;
    assign rounds_sat = (in_rounds > 4'(GASCON_MAX_ROUNDS)) ? 4'(GASCON_MAX_ROUNDS) : in_rounds;
    assign step       = (rem_q < 4'(UNROLL)) ? rem_q : 4'(UNROLL);

    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        rem_d   = rem_q;
        unique case (st_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = in_state;
                    rnd_d   = 4'(GASCON_MAX_ROUNDS) - rounds_sat;
                    rem_d   = rounds_sat;
                    st_d    = (rounds_sat == 4'd0) ? StDone : StRun;
                end
            end
            StRun: begin
                state_d = perm_out;
                rnd_d   = rnd_q + step;
                rem_d   = rem_q - step;
                if (rem_q == step) begin
                    st_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    st_d = StIdle;
`ifdef GASCON_PERM_ZEROIZE_EN
                    state_d = '0;
`else
                    state_d = state_q;
`endif
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= StIdle;
            state_q <= '0;
            rnd_q   <= 4'd0;
            rem_q   <= 4'd0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
            rem_q   <= rem_d;
        end
    end

    assign in_ready  = (st_q == StIdle) && !rst;
    assign out_valid = (st_q == StDone);
    assign busy      = (st_q != StIdle);
    assign out_state = state_q;

endmodule

// File: tb/tb_gascon_perm_iter.sv
module tb_gascon_perm_iter;

    localparam int unsigned NW     = 9;
    localparam int unsigned UNROLL = 4;
    localparam int unsigned SW     = 64 * NW;

`ifdef GASCON_PERM_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_state;
    logic [3:0]    in_rounds;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_state;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    gascon_perm_iter #(
        .NW     (NW),
        .UNROLL (UNROLL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_rounds (in_rounds),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int unsigned rot_a [9] = '{19, 61, 1, 10, 7, 31, 53, 9, 43};
    int unsigned rot_b [9] = '{28, 38, 6, 17, 40, 26, 58, 46, 50};

    // Word holds even bits of a natural 64-bit value in [31:0], odd bits in
    // [63:32]; rotate that natural value and re-split it.
    function automatic logic [63:0] m_rot(input logic [63:0] x, input int unsigned s);
        logic [63:0] n;
        logic [63:0] r;
        logic [63:0] o;
        for (int b = 0; b < 32; b++) begin
            n[2*b]     = x[b];
            n[2*b + 1] = x[32 + b];
        end
        r = (n >> s) | (n << (64 - s));
        for (int b = 0; b < 32; b++) begin
            o[b]      = r[2*b];
            o[32 + b] = r[2*b + 1];
        end
        return o;
    endfunction

    function automatic int sat(input int r);
        return (r > 12) ? 12 : r;
    endfunction

    function automatic logic [SW-1:0] model_perm(input logic [SW-1:0] s, input int rounds);
        logic [63:0] x [NW];
        logic [63:0] t [NW];
        logic [63:0] be;
        logic [SW-1:0] res;
        int m;
        m = NW / 2;
        for (int i = 0; i < NW; i++) begin
            be   = s[SW-1-64*i -: 64];
            x[i] = {<<8{be}};
        end
        for (int rr = 12 - rounds; rr < 12; rr++) begin
            x[m] = x[m] ^ 64'((15 - rr) * 16 + rr);
            for (int i = 0; i <= m; i++) x[2*i] = x[2*i] ^ x[(2*i + NW - 1) % NW];
            for (int i = 0; i < NW; i++) t[i] = ~x[i] & x[(i + 1) % NW];
            for (int i = 0; i < NW; i++) x[i] = x[i] ^ t[(i + 1) % NW];
            for (int i = 0; i <= m; i++) x[(2*i + 1) % NW] = x[(2*i + 1) % NW] ^ x[2*i];
            x[m] = ~x[m];
            for (int i = 0; i < NW; i++) x[i] = x[i] ^ m_rot(x[i], rot_a[i]) ^ m_rot(x[i], rot_b[i]);
        end
        for (int i = 0; i < NW; i++) begin
            be = {<<8{x[i]}};
            res[SW-1-64*i -: 64] = be;
        end
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] v;
        for (int i = 0; i < NW * 2; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Full transaction: accept, wait for result, check, take result.
    task automatic run_req(input logic [SW-1:0] s, input logic [3:0] r, input string tag);
        logic [SW-1:0] exp;
        int lat_exp;
        int n;
        bit saw_ready;
        exp     = model_perm(s, sat(int'(r)));
        lat_exp = (sat(int'(r)) == 0) ? 0 : (sat(int'(r)) + UNROLL - 1) / UNROLL;
        in_valid  = 1'b1;
        in_state  = s;
        in_rounds = r;
        check({tag, " in_ready"}, SW'(in_ready), SW'(1));
        tick();
        in_valid  = 1'b0;
        in_state  = rand_state();
        in_rounds = 4'($urandom_range(0, 15));
        n = 0;
        saw_ready = 1'b0;
        while (!out_valid && n < 64) begin
            if (in_ready) saw_ready = 1'b1;
            tick();
            n++;
        end
        // Edges after the accept edge until out_valid is seen.
        check({tag, " latency"}, SW'(n), SW'(lat_exp));
        check({tag, " in_ready low while running"}, SW'(saw_ready), SW'(0));
        check({tag, " busy"}, SW'(busy), SW'(1));
        check({tag, " out_state"}, out_state, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, SW'(out_valid), SW'(0));
        check({tag, " idle in_ready"}, SW'(in_ready), SW'(1));
        check({tag, " idle out_state"}, out_state, ZEROIZE ? '0 : exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [SW-1:0] s1;
        logic [SW-1:0] s2;
        logic [SW-1:0] pat;
        logic [SW-1:0] exp1;
        int n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_rounds = 4'd0;
        out_ready = 1'b0;

        #2;
        check("reset out_valid", SW'(out_valid), SW'(0));
        check("reset busy", SW'(busy), SW'(0));
        check("reset out_state", out_state, '0);
        #10 rst = 1'b0;
        #1;
        check("reset release in_ready", SW'(in_ready), SW'(1));
        tick();

        run_req('0, 4'd12, "r12 zero");
        run_req(rand_state(), 4'd11, "r11");
        s1 = rand_state();
        run_req(s1, 4'd13, "r13");
        run_req(s1, 4'd12, "r12 same");

        for (int i = 0; i < NW; i++) pat[SW-1-64*i -: 64] = 64'h0123_4567_89AB_CDEF;
        run_req(pat, 4'd0, "r0 pattern");

        for (int i = 0; i < 10; i++) begin
            run_req(rand_state(), 4'($urandom_range(0, 15)), "random");
        end

        // Back-pressure: result held, second request ignored until released.
        s1   = rand_state();
        exp1 = model_perm(s1, 5);
        in_valid  = 1'b1;
        in_state  = s1;
        in_rounds = 4'd5;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 64) begin
            tick();
            n++;
        end
        check("bp latency", SW'(n), SW'(2));
        s2 = rand_state();
        in_valid  = 1'b1;
        in_state  = s2;
        in_rounds = 4'd3;
        for (int c = 0; c < 20; c++) begin
            check("bp hold out_state", out_state, exp1);
            check("bp hold in_ready", SW'(in_ready), SW'(0));
            check("bp hold out_valid", SW'(out_valid), SW'(1));
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release out_valid", SW'(out_valid), SW'(0));
        check("bp release in_ready", SW'(in_ready), SW'(1));
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 64) begin
            tick();
            n++;
        end
        check("bp second latency", SW'(n), SW'(1));
        check("bp second out_state", out_state, model_perm(s2, 3));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a run.
        in_valid  = 1'b1;
        in_state  = rand_state();
        in_rounds = 4'd12;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid-run busy", SW'(busy), SW'(1));
        #3 rst = 1'b1;
        #1;
        check("abort out_valid", SW'(out_valid), SW'(0));
        check("abort busy", SW'(busy), SW'(0));
        check("abort out_state", out_state, '0);
        #2 rst = 1'b0;
        #1;
        check("abort release in_ready", SW'(in_ready), SW'(1));
        n = 0;
        repeat (6) begin
            tick();
            if (out_valid) n++;
        end
        check("abort no spurious output", SW'(n), SW'(0));
        run_req(rand_state(), 4'd12, "post-abort r12");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
